// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch front-end and the control unit that consumes
// its T/OPC/pc_bits split.
package instr_fetch_unit_pkg;

   localparam int unsigned FETCH_ADDR_W  = 32;
   localparam int unsigned FETCH_INSTR_W = 32;

   localparam int unsigned T_MSB   = 31;
   localparam int unsigned T_LSB   = 30;
   localparam int unsigned OPC_MSB = 29;
   localparam int unsigned OPC_LSB = 27;

   localparam logic [1:0] MOVEMENT     = 2'b00;
   localparam logic [1:0] LOGIC        = 2'b01;
   localparam logic [1:0] ARITHMETIC   = 2'b10;
   localparam logic [1:0] FLOW_CONTROL = 2'b11;

   localparam logic [2:0] OPC_JUMP   = 3'b000;
   localparam logic [2:0] OPC_BRANCH = 3'b001;
   localparam logic [2:0] OPC_JAL    = 3'b010;
   localparam logic [2:0] OPC_JRAL   = 3'b011;
   localparam logic [2:0] OPC_RET    = 3'b100;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_FAULT
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0]  pc;
      logic [FETCH_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Redirect, instruction-memory and decode-handshake signals of the fetch unit.
// master = fetch unit side, slave = memory/decode/control side.
interface instr_fetch_unit_if
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W  = FETCH_ADDR_W,
   parameter int unsigned INSTR_W = FETCH_INSTR_W
);
   logic               redirect_i;
   logic [ADDR_W-1:0]  redirect_pc_i;
   logic               imem_req_o;
   logic [ADDR_W-1:0]  imem_addr_o;
   logic               imem_gnt_i;
   logic               imem_rvalid_i;
   logic [INSTR_W-1:0] imem_rdata_i;
   logic               if_valid_o;
   logic               id_ready_i;
   logic [INSTR_W-1:0] instr_o;
   logic [1:0]         T_o;
   logic [2:0]         OPC_o;
   logic [ADDR_W-1:0]  pc_o;
   logic [1:0]         pc_bits_o;
   logic               misalign_o;

   modport master (
      input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
      output imem_req_o, imem_addr_o, if_valid_o, instr_o, T_o, OPC_o, pc_o, pc_bits_o, misalign_o
   );

   modport slave (
      output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
      input  imem_req_o, imem_addr_o, if_valid_o, instr_o, T_o, OPC_o, pc_o, pc_bits_o, misalign_o
   );
endinterface

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Synchronous FIFO with clear; used both for fetched {pc, instr} entries and
// for the per-request PC queue.
module fetch_buffer #(
   parameter int unsigned W     = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   input  logic                       clear,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front-end: issues instruction-memory requests, buffers responses and
// presents them to decode; flushes on control-unit redirects.
//
// state | meaning
// RUN   | normal fetch, responses buffered
// DRAIN | redirect pending, stale responses dropped, no requests
// FAULT | misaligned target held as a fault entry until next redirect
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
   parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
   parameter int unsigned       DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic                clk,
   input logic                rst,
   instr_fetch_unit_if.master bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned ENT_W = ADDR_W + INSTR_W;
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fault_pc_q, req_pc, pc;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0]   outstanding, out_next, buf_count, occ_after;
   logic [CNT_W:0]     inflight;
   logic [ENT_W-1:0]   head;
   logic [INSTR_W-1:0] instr;
   logic               buf_full, buf_empty, pcq_full, pcq_empty;
   logic               req, issue, rsp, keep, pop, valid, misalign;

   // outstanding is the PC queue depth: one entry per issued, unanswered request
   fetch_buffer #(.W(ADDR_W), .DEPTH(DEPTH)) u_pc_queue (
      .clk(clk), .rst(rst), .push(issue), .wdata(fetch_pc_q), .pop(rsp), .clear(1'b0),
      .rdata(req_pc), .count(outstanding), .full(pcq_full), .empty(pcq_empty)
   );

   fetch_buffer #(.W(ENT_W), .DEPTH(DEPTH)) u_fetch_buffer (
      .clk(clk), .rst(rst), .push(keep), .wdata({req_pc, bus.imem_rdata_i}), .pop(pop),
      .clear(bus.redirect_i), .rdata(head), .count(buf_count), .full(buf_full), .empty(buf_empty)
   );

   assign rsp       = bus.imem_rvalid_i && !pcq_empty;
   assign pop       = !rst && (state_q == ST_RUN) && !buf_empty && bus.id_ready_i;
   assign occ_after = buf_count - CNT_W'(pop);
   assign inflight  = {1'b0, outstanding} + {1'b0, occ_after};
   assign req       = !rst && (state_q == ST_RUN) && !bus.redirect_i && !pcq_full && (inflight < DEPTH_L);
   assign issue     = req && bus.imem_gnt_i;
   assign keep      = rsp && (state_q == ST_RUN) && !bus.redirect_i && !buf_full;
   assign out_next  = outstanding + CNT_W'(issue) - CNT_W'(rsp);

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (bus.redirect_i)
         drop_cnt_d = out_next;
      else if ((state_q != ST_RUN) && rsp && (drop_cnt_q != '0))
         drop_cnt_d = drop_cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.redirect_i) begin
         if (bus.redirect_pc_i[1:0] != 2'b00) state_d = ST_FAULT;
         else if (out_next != '0)             state_d = ST_DRAIN;
         else                                 state_d = ST_RUN;
      end else if ((state_q == ST_DRAIN) && (drop_cnt_d == '0)) begin
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         fault_pc_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         if (bus.redirect_i) begin
            fetch_pc_q <= bus.redirect_pc_i;
            fault_pc_q <= bus.redirect_pc_i;
         end else if (issue) begin
            fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
         end
      end
   end

   always_comb begin
      valid    = 1'b0;
      misalign = 1'b0;
      instr    = '0;
      pc       = '0;
      if (!rst) begin
         case (state_q)
            ST_RUN: begin
               if (!buf_empty) begin
                  valid = 1'b1;
                  instr = head[INSTR_W-1:0];
                  pc    = head[ENT_W-1:INSTR_W];
               end
            end
            ST_FAULT: begin
               valid    = 1'b1;
               misalign = 1'b1;
               pc       = fault_pc_q;
            end
            default: ;
         endcase
      end
      bus.imem_req_o  = req;
      bus.imem_addr_o = fetch_pc_q;
      bus.if_valid_o  = valid;
      bus.misalign_o  = misalign;
      bus.instr_o     = instr;
      bus.T_o         = instr[T_MSB:T_LSB];
      bus.OPC_o       = instr[OPC_MSB:OPC_LSB];
      bus.pc_o        = pc;
      bus.pc_bits_o   = pc[1:0];
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural imem with programmable latency,
// epoch-tagged requests and an expected-entry scoreboard.
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } pend_t;

   logic clk;
   logic rst;
   instr_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus();

   instr_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pend_t        pend[$];
   fetch_entry_t sb[$];
   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int epoch  = 0;
   int lat    = 1;
   int issued;
   int n;

   logic        d_rvalid;
   logic        s_req, s_valid, s_mis;
   logic [31:0] s_addr, s_instr, s_pc;
   logic [1:0]  s_t, s_pcb;
   logic [2:0]  s_opc;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (32'h8000_0000 ^ (a << 28)) | (a >> 3);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive the memory response, sample outputs, update the model.
   task automatic cycle();
      pend_t        p;
      fetch_entry_t e;
      d_rvalid = 1'b0;
      bus.imem_rdata_i = 32'hDEAD_BEEF;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         p = pend.pop_front();
         d_rvalid = 1'b1;
         bus.imem_rdata_i = word_of(p.addr);
         if (p.epoch == epoch && !bus.redirect_i && !rst)
            sb.push_back('{pc: p.addr, instr: word_of(p.addr)});
      end
      bus.imem_rvalid_i = d_rvalid;
      #1;
      s_req = bus.imem_req_o;  s_addr = bus.imem_addr_o;
      s_valid = bus.if_valid_o; s_mis = bus.misalign_o;
      s_instr = bus.instr_o;   s_pc = bus.pc_o;
      s_t = bus.T_o;           s_opc = bus.OPC_o; s_pcb = bus.pc_bits_o;
      if (!rst && s_req && bus.imem_gnt_i)
         pend.push_back('{addr: s_addr, epoch: epoch, due: cyc + lat});
      if (!rst && s_valid && bus.id_ready_i && !s_mis) begin
         chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_pc", 64'(s_pc), 64'(e.pc));
            chk("sb_instr", 64'(s_instr), 64'(e.instr));
         end
      end
      if (!rst && bus.redirect_i) begin
         epoch++;
         sb.delete();
      end
      if (rst) begin
         pend.delete();
         sb.delete();
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_valid();
      n = 0;
      do begin cycle(); n++; end while (!s_valid && n < 20);
   endtask

   initial begin
      rst = 1'b1;
      bus.redirect_i = 1'b0;  bus.redirect_pc_i = '0;
      bus.imem_gnt_i = 1'b1;  bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i = '0;  bus.id_ready_i = 1'b1;
      d_rvalid = 1'b0;
      @(negedge clk);

      // reset
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("rst_req", 64'(s_req), 64'(0));     chk("rst_valid", 64'(s_valid), 64'(0));
         chk("rst_mis", 64'(s_mis), 64'(0));     chk("rst_instr", 64'(s_instr), 64'(0));
         chk("rst_pc", 64'(s_pc), 64'(0));       chk("rst_t", 64'(s_t), 64'(0));
         chk("rst_opc", 64'(s_opc), 64'(0));     chk("rst_pcbits", 64'(s_pcb), 64'(0));
      end
      rst = 1'b0;
      cycle(); chk("t1_req0", 64'(s_req), 64'(1)); chk("t1_addr0", 64'(s_addr), 64'(0));
      cycle(); chk("t1_addr1", 64'(s_addr), 64'(4));
      cycle(); chk("t1_addr2", 64'(s_addr), 64'(8));
      chk("t2_valid0", 64'(s_valid), 64'(1)); chk("t2_pc0", 64'(s_pc), 64'(0));
      chk("t2_t0", 64'(s_t), 64'(2'b10));     chk("t2_opc0", 64'(s_opc), 64'(0));
      chk("t2_instr0", 64'(s_instr), 64'(32'h8000_0000));
      cycle(); chk("t2_valid1", 64'(s_valid), 64'(1)); chk("t2_pc1", 64'(s_pc), 64'(4));
      chk("t2_t1", 64'(s_t), 64'(2'b11));
      repeat (4) cycle();

      // backpressure
      rst = 1'b1; cycle(); rst = 1'b0;
      bus.id_ready_i = 1'b0;
      issued = 0;
      repeat (10) begin
         cycle();
         if (s_req && bus.imem_gnt_i) issued++;
      end
      chk("t3_issued", 64'(issued), 64'(2));  chk("t3_req_off", 64'(s_req), 64'(0));
      chk("t3_hold_valid", 64'(s_valid), 64'(1)); chk("t3_hold_pc", 64'(s_pc), 64'(0));
      bus.id_ready_i = 1'b1;
      cycle(); chk("t3_rel_pc0", 64'(s_pc), 64'(0)); chk("t3_rel_v0", 64'(s_valid), 64'(1));
      cycle(); chk("t3_rel_pc1", 64'(s_pc), 64'(4)); chk("t3_rel_v1", 64'(s_valid), 64'(1));

      // flush with two late responses
      lat = 3;
      rst = 1'b1; cycle(); rst = 1'b0;
      cycle(); cycle();
      bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h40;
      cycle(); chk("t4_req_redir", 64'(s_req), 64'(0));
      bus.redirect_i = 1'b0;
      repeat (2) begin
         cycle();
         chk("t4_late_rvalid", 64'(d_rvalid), 64'(1));
         chk("t4_drain_req", 64'(s_req), 64'(0));
         chk("t4_drain_valid", 64'(s_valid), 64'(0));
      end
      cycle(); chk("t4_req40", 64'(s_req), 64'(1)); chk("t4_addr40", 64'(s_addr), 64'(32'h40));
      wait_valid();
      chk("t4_valid", 64'(s_valid), 64'(1)); chk("t4_pc", 64'(s_pc), 64'(32'h40));

      // misaligned target
      bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h42;
      cycle();
      bus.redirect_i = 1'b0;
      repeat (5) begin
         cycle();
         chk("t5_valid", 64'(s_valid), 64'(1)); chk("t5_mis", 64'(s_mis), 64'(1));
         chk("t5_pcbits", 64'(s_pcb), 64'(2'b10)); chk("t5_req", 64'(s_req), 64'(0));
         chk("t5_pc", 64'(s_pc), 64'(32'h42)); chk("t5_instr", 64'(s_instr), 64'(0));
      end
      bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h100;
      cycle();
      bus.redirect_i = 1'b0;
      n = 0;
      do begin cycle(); n++; end while (!s_req && n < 20);
      chk("t5_resume_req", 64'(s_req), 64'(1)); chk("t5_resume_addr", 64'(s_addr), 64'(32'h100));
      wait_valid();
      chk("t5_resume_valid", 64'(s_valid), 64'(1)); chk("t5_resume_pc", 64'(s_pc), 64'(32'h100));
      chk("t5_resume_mis", 64'(s_mis), 64'(0));

      // redirect + rvalid + consume in one cycle
      lat = 1;
      repeat (6) cycle();
      bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h200;
      cycle();
      chk("t6_rvalid", 64'(d_rvalid), 64'(1));
      chk("t6_consume", 64'(s_valid && bus.id_ready_i), 64'(1));
      bus.redirect_i = 1'b0;
      cycle();
      chk("t6_flushed", 64'(s_valid), 64'(0));
      chk("t6_req", 64'(s_req), 64'(1)); chk("t6_addr", 64'(s_addr), 64'(32'h200));
      wait_valid();
      chk("t6_valid", 64'(s_valid), 64'(1)); chk("t6_pc", 64'(s_pc), 64'(32'h200));
      chk("t6_instr", 64'(s_instr), 64'(word_of(32'h200)));

      // address wrap
      bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFFC;
      cycle();
      bus.redirect_i = 1'b0;
      cycle(); chk("wrap_req", 64'(s_req), 64'(1)); chk("wrap_addr0", 64'(s_addr), 64'(32'hFFFF_FFFC));
      cycle(); chk("wrap_addr1", 64'(s_addr), 64'(0));
      wait_valid();
      chk("wrap_pc", 64'(s_pc), 64'(32'hFFFF_FFFC));
      repeat (3) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
